lc3b_mem_responder: RTL and testbench
=====================================

Name: lc3b_mem_responder

Overview:
- Memory-side responder for the LC-3b CPU memory interface: word-addressed backing store with programmable access latency.
- Accepts read and write requests, applies byte-enables on writes, and returns a one-cycle mem_resp pulse with read data.
- Stands in for physical memory at the CPU top level. It pairs the CPU's mem_read/mem_write/mem_address/mem_wdata/mem_byte_enable outputs with its mem_resp/mem_rdata inputs.

Parameters:
- DEPTH_WORDS, 32768: number of 16-bit words in the store; valid word index 0..DEPTH_WORDS-1.
- LATENCY, 4: cycles from request acceptance to mem_resp; legal range 1..255.

Ports:
- clk  input  1  Single clock; all state changes on the rising edge.
- rst  input  1  Synchronous, active-high reset.
- mem_read  input  1  Read request; held by the requester until mem_resp.
- mem_write  input  1  Write request; held by the requester until mem_resp.
- mem_byte_enable  input  2  Write byte mask; bit0 = low byte [7:0], bit1 = high byte [15:8].
- mem_address  input  16  Byte address; word index = mem_address[15:1]; bit0 is ignored.
- mem_wdata  input  16  Write data.
- mem_resp  output  1  One-cycle completion pulse.
- mem_rdata  output  16  Read data; valid while mem_resp is high.
- busy  output  1  High while a transaction is in WAIT or RESP.
- err  output  1  Sticky error flag.

Behaviour:
- Reset (rst high at an edge):
  - mem_resp=0, mem_rdata=16'h0000, busy=0, err=0, latency counter=0, FSM to IDLE.
  - Array contents are NOT cleared.
  - Reset mid-transaction abandons the transaction; a pending write is not committed.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If mem_read or mem_write is high, latch address, wdata, byte_enable and op; load counter = LATENCY-1; go to WAIT.
  - If LATENCY==1, go directly to RESP.
- Simultaneous mem_read and mem_write at accept: set err, treat as a read, commit no write.
- WAIT:
  - Counter decrements each cycle; at counter==1 go to RESP.
  - Net timing: request first high in IDLE cycle N -> mem_resp high in cycle N+LATENCY.
  - If both mem_read and mem_write are low in any WAIT cycle, abort: return to IDLE, no resp, no write.
- RESP:
  - mem_resp=1 for exactly one cycle.
  - Read: mem_rdata is registered on the edge entering RESP from the latched word index, and holds its value after RESP until the next read response.
  - Write: committed on the edge leaving RESP, per latched mask. Masked-off bytes are unchanged; mask 2'b00 writes nothing but still responds.
  - Writes leave mem_rdata unchanged.
  - Always returns to IDLE.
- Back-to-back requests:
  - The cycle after RESP is IDLE; a request still asserted there is accepted as a NEW transaction.
  - Minimum spacing between responses is therefore LATENCY+1 cycles.
  - Read-after-write to the same address returns the new data.
- Out-of-range (word index >= DEPTH_WORDS):
  - Transaction completes with normal timing.
  - Read returns 16'h0000; write is dropped; err is set.
- Requester contract: the address and data fields are sampled only at accept. Later changes are ignored by this transaction.
- busy = (state != IDLE).
- err clears only on rst.

Test Plan:
- LATENCY=4; write 16'hBEEF to 16'h0010 with mask 2'b11, then read 16'h0010 -> each mem_resp occurs exactly 4 cycles after request; read returns 16'hBEEF.
- Byte writes: preload 16'h1234 at 16'h0020; write 16'hAB00 with mask 2'b10, then 16'h00CD to 16'h0021 (bit0 ignored) with mask 2'b01 -> read returns 16'hABCD.
- Abort: start a write of 16'h5555 to 16'h0030; drop mem_write after 2 WAIT cycles -> no mem_resp, busy falls next cycle, later read of 16'h0030 returns the prior value.
- Read and write both asserted at 16'h0040, then out-of-range read with DEPTH_WORDS=256 at 16'h0400 -> err=1 after the first; second returns 16'h0000 with normal latency; err stays 1 until rst.
- LATENCY=1; hold mem_read across mem_resp -> resp pulses every 2 cycles, each pulse exactly 1 cycle wide.
- Assert rst during WAIT of a write of 16'h7777 to 16'h0050 -> mem_resp=0, busy=0, err=0 next cycle; subsequent read of 16'h0050 returns the old value.

Source files
------------

// File: rtl/lc3b_mem_responder.sv
// lc3b_mem_responder: word-addressed backing store that answers LC-3b
// mem_read/mem_write requests after a fixed, programmable latency. Supports
// byte-enabled writes, abort on request withdrawal, and a sticky error flag.
module lc3b_mem_responder #(
   parameter int DEPTH_WORDS = 32768,  // 16-bit words in the store (at most 32768)
   parameter int LATENCY     = 4       // request-to-response cycles, 1..255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  mem_byte_enable,
   input  logic [15:0] mem_address,
   input  logic [15:0] mem_wdata,
   output logic        mem_resp,
   output logic [15:0] mem_rdata,
   output logic        busy,
   output logic        err
);

   localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [7:0] LOAD_CNT = 8'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        err_q, err_d;
   logic [15:0] rdata_q, rdata_d;

   // Request fields captured at accept; the requester may change its
   // outputs afterwards without affecting the transaction in flight.
   logic [14:0] widx_q;
   logic [15:0] wdata_q;
   logic [1:0]  be_q;
   logic        wr_q;
   logic        inrng_q;

   logic [15:0] mem_q [DEPTH_WORDS];

   logic        req;
   logic        accept;
   logic [14:0] req_widx;
   logic        req_inrng;
   logic [14:0] look_idx;
   logic        look_inrng;
   logic [15:0] look_word;
   logic        commit;
   logic        unused_bits;

   assign req       = mem_read | mem_write;
   assign req_widx  = mem_address[15:1];
   assign req_inrng = ({17'd0, req_widx} < 32'(DEPTH_WORDS));

   // With LATENCY==1 the read happens on the accept edge, before the
   // captured index exists, so the lookup uses the live request in IDLE.
   assign look_idx   = (state_q == S_IDLE) ? req_widx  : widx_q;
   assign look_inrng = (state_q == S_IDLE) ? req_inrng : inrng_q;
   assign look_word  = look_inrng ? mem_q[look_idx[IDX_W-1:0]] : 16'h0000;

   // A write lands on the edge leaving RESP unless reset abandons it there.
   assign commit = (state_q == S_RESP) && wr_q && inrng_q && !rst;

   assign mem_resp  = (state_q == S_RESP);
   assign busy      = (state_q != S_IDLE);
   assign mem_rdata = rdata_q;
   assign err       = err_q;

   assign unused_bits = ^{mem_address[0], look_idx, widx_q};

   // Next-state, counter, error and read-data selection.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      accept  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (req) begin
               accept = 1'b1;
               cnt_d  = LOAD_CNT;
               // Read+write together is flagged and served as a read;
               // out-of-range requests are flagged but still complete.
               if ((mem_read && mem_write) || !req_inrng) begin
                  err_d = 1'b1;
               end
               if (LATENCY == 1) begin
                  state_d = S_RESP;
                  if (mem_read) begin
                     rdata_d = look_word;
                  end
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 8'd1;
            if (!req) begin
               // Requester withdrew: drop the transaction silently.
               state_d = S_IDLE;
            end else if (cnt_q == 8'd1) begin
               state_d = S_RESP;
               if (!wr_q) begin
                  rdata_d = look_word;
               end
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control state: FSM, latency counter, sticky error, read-data register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         err_q   <= 1'b0;
         rdata_q <= 16'h0000;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // Capture the request fields when a transaction is accepted.
   always_ff @(posedge clk) begin
      if (accept) begin
         widx_q  <= req_widx;
         wdata_q <= mem_wdata;
         be_q    <= mem_byte_enable;
         wr_q    <= mem_write & ~mem_read;
         inrng_q <= req_inrng;
      end
   end

   // Byte-masked write into the backing store; contents survive reset.
   always_ff @(posedge clk) begin
      if (commit) begin
         if (be_q[0]) begin
            mem_q[widx_q[IDX_W-1:0]][7:0] <= wdata_q[7:0];
         end
         if (be_q[1]) begin
            mem_q[widx_q[IDX_W-1:0]][15:8] <= wdata_q[15:8];
         end
      end
   end

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Directed bench for lc3b_mem_responder: one instance with LATENCY=4 and a
// 256-word store, one with LATENCY=1; shared stimulus gated by sel_b.
module tb_lc3b_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write;
   logic [1:0]  mem_byte_enable;
   logic [15:0] mem_address, mem_wdata;
   logic        sel_b;

   logic        rd_a, wr_a, rd_b, wr_b;
   logic        resp_a, busy_a, err_a, resp_b, busy_b, err_b;
   logic [15:0] rdata_a, rdata_b;
   logic        o_resp;
   logic [15:0] o_rdata;

   int nvec = 0;
   int nmis = 0;

   always #5 clk = ~clk;

   assign rd_a    = mem_read  & ~sel_b;
   assign wr_a    = mem_write & ~sel_b;
   assign rd_b    = mem_read  &  sel_b;
   assign wr_b    = mem_write &  sel_b;
   assign o_resp  = sel_b ? resp_b  : resp_a;
   assign o_rdata = sel_b ? rdata_b : rdata_a;

   lc3b_mem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) dut_a (
      .clk(clk), .rst(rst),
      .mem_read(rd_a), .mem_write(wr_a),
      .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
      .mem_wdata(mem_wdata),
      .mem_resp(resp_a), .mem_rdata(rdata_a), .busy(busy_a), .err(err_a)
   );

   lc3b_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut_b (
      .clk(clk), .rst(rst),
      .mem_read(rd_b), .mem_write(wr_b),
      .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
      .mem_wdata(mem_wdata),
      .mem_resp(resp_b), .mem_rdata(rdata_b), .busy(busy_b), .err(err_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      if (obs !== exp) begin
         nmis++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // One full handshake; request fields are scrambled after accept.
   task automatic xact(input logic rd, input logic wr, input logic [15:0] a,
                       input logic [15:0] d, input logic [1:0] be,
                       output int lat, output logic [15:0] data);
      @(negedge clk);
      mem_read = rd; mem_write = wr; mem_address = a; mem_wdata = d; mem_byte_enable = be;
      lat  = -1;
      data = 16'hxxxx;
      for (int i = 1; i <= 300; i++) begin
         @(negedge clk);
         if (o_resp) begin
            lat  = i;
            data = o_rdata;
            break;
         end
         mem_address = ~a;
         mem_wdata   = ~d;
         mem_byte_enable = ~be;
      end
      mem_read = 1'b0;
      mem_write = 1'b0;
   endtask

   task automatic do_wr(input string tag, input logic [15:0] a, input logic [15:0] d,
                        input logic [1:0] be);
      int lat;
      logic [15:0] q;
      xact(1'b0, 1'b1, a, d, be, lat, q);
      check({tag, "_lat"}, 32'(lat), sel_b ? 32'd1 : 32'd4);
   endtask

   task automatic do_rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
      int lat;
      logic [15:0] q;
      xact(1'b1, 1'b0, a, 16'h0000, 2'b00, lat, q);
      check({tag, "_lat"}, 32'(lat), sel_b ? 32'd1 : 32'd4);
      check({tag, "_data"}, 32'(q), 32'(exp));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int npulse;
      logic [15:0] q;
      logic [7:0]  pat;

      rst = 1'b1; sel_b = 1'b0;
      mem_read = 1'b0; mem_write = 1'b0;
      mem_byte_enable = 2'b00; mem_address = 16'h0000; mem_wdata = 16'h0000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_resp_a",  32'(resp_a),  32'd0);
      check("rst_rdata_a", 32'(rdata_a), 32'd0);
      check("rst_busy_a",  32'(busy_a),  32'd0);
      check("rst_err_a",   32'(err_a),   32'd0);
      check("rst_resp_b",  32'(resp_b),  32'd0);
      check("rst_busy_b",  32'(busy_b),  32'd0);
      rst = 1'b0;

      // Full-word write then read back
      do_wr("w10", 16'h0010, 16'hBEEF, 2'b11);
      do_rd("r10", 16'h0010, 16'hBEEF);
      check("err_clean", 32'(err_a), 32'd0);

      // Byte-enable merging, bit0 of address ignored, mask 00 writes nothing
      do_wr("w20_full", 16'h0020, 16'h1234, 2'b11);
      do_wr("w20_hi",   16'h0020, 16'hAB00, 2'b10);
      do_wr("w21_lo",   16'h0021, 16'h00CD, 2'b01);
      do_rd("r20", 16'h0020, 16'hABCD);
      do_wr("w20_m00",  16'h0020, 16'hFFFF, 2'b00);
      check("rdata_hold_after_wr", 32'(rdata_a), 32'h0000ABCD);
      do_rd("r20_after_m00", 16'h0020, 16'hABCD);

      // Abort: withdraw a write during WAIT
      do_wr("w30_prior", 16'h0030, 16'h1111, 2'b11);
      @(negedge clk);
      mem_write = 1'b1; mem_address = 16'h0030; mem_wdata = 16'h5555; mem_byte_enable = 2'b11;
      @(negedge clk);
      check("abort_busy_w1", 32'(busy_a), 32'd1);
      @(negedge clk);
      check("abort_busy_w2", 32'(busy_a), 32'd1);
      mem_write = 1'b0;
      @(negedge clk);
      check("abort_busy_fall", 32'(busy_a), 32'd0);
      npulse = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (resp_a) npulse++;
      end
      check("abort_no_resp", 32'(npulse), 32'd0);
      do_rd("r30", 16'h0030, 16'h1111);

      // Simultaneous read+write: error, served as read, nothing written
      do_wr("w40", 16'h0040, 16'h4242, 2'b11);
      check("err_before_both", 32'(err_a), 32'd0);
      xact(1'b1, 1'b1, 16'h0040, 16'h9999, 2'b11, lat, q);
      check("both_lat",  32'(lat), 32'd4);
      check("both_data", 32'(q),   32'h00004242);
      check("both_err",  32'(err_a), 32'd1);
      do_rd("r40", 16'h0040, 16'h4242);

      // Out of range (word index >= 256)
      do_wr("w00", 16'h0000, 16'h0A0A, 2'b11);
      xact(1'b1, 1'b0, 16'h0400, 16'h0000, 2'b00, lat, q);
      check("oor_rd_lat",  32'(lat), 32'd4);
      check("oor_rd_data", 32'(q),   32'd0);
      do_wr("oor_wr", 16'h0600, 16'hDEAD, 2'b11);
      do_rd("r00_no_alias", 16'h0000, 16'h0A0A);
      check("err_sticky", 32'(err_a), 32'd1);

      // Reset during WAIT of a write
      do_wr("w50_prior", 16'h0050, 16'h5050, 2'b11);
      @(negedge clk);
      mem_write = 1'b1; mem_address = 16'h0050; mem_wdata = 16'h7777; mem_byte_enable = 2'b11;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1; mem_write = 1'b0;
      @(negedge clk);
      check("rstw_resp",  32'(resp_a),  32'd0);
      check("rstw_busy",  32'(busy_a),  32'd0);
      check("rstw_err",   32'(err_a),   32'd0);
      check("rstw_rdata", 32'(rdata_a), 32'd0);
      rst = 1'b0;
      do_rd("r50", 16'h0050, 16'h5050);

      // LATENCY=1 instance: held read responds every other cycle
      sel_b = 1'b1;
      do_wr("b_w10", 16'h0010, 16'h0B0B, 2'b11);
      @(negedge clk);
      mem_read = 1'b1; mem_address = 16'h0010;
      pat = 8'h00;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         pat = {pat[6:0], resp_b};
      end
      mem_read = 1'b0;
      check("b_resp_pattern", 32'(pat), 32'h000000AA);
      check("b_rdata", 32'(rdata_b), 32'h00000B0B);
      repeat (3) @(negedge clk);
      check("b_idle_busy", 32'(busy_b), 32'd0);
      check("b_idle_resp", 32'(resp_b), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
